// File: rtl/seven_seg_scan_if.sv
// Display-side signal bundle for the seven-segment scan controller.
// Master drives the digit data and enable; slave drives the pins.
interface seven_seg_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    Enable;
   logic [4*NUM_DIGITS-1:0] Digits;
   logic [NUM_DIGITS-1:0]   DP_in;
   logic [7:0]              Segment;
   logic [NUM_DIGITS-1:0]   Anode;
   logic                    Frame_done;

   modport master (
      output Enable, Digits, DP_in,
      input  Segment, Anode, Frame_done
   );

   modport slave (
      input  Enable, Digits, DP_in,
      output Segment, Anode, Frame_done
   );
endinterface

// File: rtl/seven_seg_scan_controller.sv
// Multiplexed hex display driver: per-frame snapshot, blanked dwell slots, active-low pins.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
//
// state | meaning
// IDLE  | display dark, waiting for Enable; snapshot taken on leaving
// BLANK | start of a slot, all anodes off to avoid ghosting
// DRIVE | remainder of the slot, selected digit lit
module seven_seg_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input logic             Clk,
   input logic             nReset,
   seven_seg_scan_if.slave scan
);
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0] snap_q, snap_d;
   logic [NUM_DIGITS-1:0]      dp_snap_q, dp_snap_d;
   logic [7:0]                 seg_q, seg_d;
   logic [NUM_DIGITS-1:0]      anode_q, anode_d;
   logic                       frame_done_q, frame_done_d;
   logic [NUM_DIGITS-1:0]      lz_blank;
`ifdef LEADING_ZERO_BLANK_EN
   logic                       zero_run;
`endif

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      snap_d       = snap_q;
      dp_snap_d    = dp_snap_q;
      frame_done_d = 1'b0;
      if (!scan.Enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               snap_d    = scan.Digits;
               dp_snap_d = scan.DP_in;
               idx_d     = '0;
               cnt_d     = '0;
               state_d   = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
            end
            ST_BLANK: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
               if (cnt_q == SLOT_LAST) begin
                  cnt_d   = '0;
                  state_d = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
                  if (idx_q == IDX_LAST) begin
                     idx_d        = '0;
                     snap_d       = scan.Digits;
                     dp_snap_d    = scan.DP_in;
                     frame_done_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Digit i>0 is a leading zero when it and every digit above it are zero.
   always_comb begin
      lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run    = zero_run & (snap_d[i] == 4'd0);
         lz_blank[i] = zero_run;
      end
`endif
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_comb begin
      seg_d   = 8'hFF;
      anode_d = '1;
      if (state_d == ST_DRIVE) begin
         anode_d = ~(NUM_DIGITS'(1) << idx_d);
         seg_d   = {~dp_snap_d[idx_d], lz_blank[idx_d] ? 7'h7F : hex7(snap_d[idx_d])};
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         snap_q       <= '0;
         dp_snap_q    <= '0;
         seg_q        <= 8'hFF;
         anode_q      <= '1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         snap_q       <= snap_d;
         dp_snap_q    <= dp_snap_d;
         seg_q        <= seg_d;
         anode_q      <= anode_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign scan.Segment    = seg_q;
   assign scan.Anode      = anode_q;
   assign scan.Frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Scoreboard bench: two controllers (blanking 2 and 0) share random stimulus and
// are checked against a frame/slot arithmetic model of the display.
module tb_seven_seg_scan_controller;
   localparam int N     = 4;
   localparam int R     = 8;
   localparam int B     = 2;
   localparam int FRAME = N * R;
   localparam logic [6:0] HEX_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [15:0] dig = '0;
   logic [3:0]  dp = '0;

   seven_seg_scan_if #(.NUM_DIGITS(N)) if_a ();
   seven_seg_scan_if #(.NUM_DIGITS(N)) if_b ();

   assign if_a.Enable = en;
   assign if_a.Digits = dig;
   assign if_a.DP_in  = dp;
   assign if_b.Enable = en;
   assign if_b.Digits = dig;
   assign if_b.DP_in  = dp;

   seven_seg_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut_a (
      .Clk(clk), .nReset(rst_n), .scan(if_a));
   seven_seg_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(0)) dut_b (
      .Clk(clk), .nReset(rst_n), .scan(if_b));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] seg_a;
      logic [3:0] an_a;
      logic [7:0] seg_b;
      logic [3:0] an_b;
      logic       fd;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Model: k counts cycles since the scan started; the snapshot refreshes every FRAME cycles.
   bit          active = 1'b0;
   int          k = 0;
   logic [15:0] snap = '0;
   logic [3:0]  dps = '0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic predict(input int blank, output logic [7:0] seg, output logic [3:0] an);
      int          d;
      logic [6:0]  g;
      logic [15:0] upper;
      seg = 8'hFF;
      an  = 4'hF;
      if (active && (k % R) >= blank) begin
         d     = (k / R) % N;
         upper = snap >> (4 * d);
         g     = HEX_TAB[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
         if (d != 0 && upper == 16'h0) g = 7'h7F;
`endif
         an  = ~(4'b0001 << d);
         seg = {~dps[d], g};
      end
   endtask

   task automatic cycle();
      exp_t e;
      @(posedge clk);
      if (!rst_n || !en) begin
         active = 1'b0;
      end else if (!active) begin
         active = 1'b1;
         k      = 0;
         snap   = dig;
         dps    = dp;
      end else begin
         k++;
         if (k % FRAME == 0) begin
            snap = dig;
            dps  = dp;
         end
      end
      predict(B, e.seg_a, e.an_a);
      predict(0, e.seg_b, e.an_b);
      e.fd = active && k > 0 && (k % FRAME == 0);
      q.push_back(e);
      #6;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic async_reset_check();
      rst_n = 1'b0;
      #1;
      chk("rst_seg_a", if_a.Segment, 8'hFF);
      chk("rst_an_a", {4'h0, if_a.Anode}, 8'h0F);
      chk("rst_fd_a", {7'h0, if_a.Frame_done}, 8'h00);
      chk("rst_seg_b", if_b.Segment, 8'hFF);
      chk("rst_an_b", {4'h0, if_b.Anode}, 8'h0F);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("seg_a", if_a.Segment, e.seg_a);
         chk("anode_a", {4'h0, if_a.Anode}, {4'h0, e.an_a});
         chk("fdone_a", {7'h0, if_a.Frame_done}, {7'h0, e.fd});
         chk("seg_b", if_b.Segment, e.seg_b);
         chk("anode_b", {4'h0, if_b.Anode}, {4'h0, e.an_b});
         chk("fdone_b", {7'h0, if_b.Frame_done}, {7'h0, e.fd});
      end
   end

   initial begin
      logic [15:0] mask;
      rst_n = 1'b0;
      en    = 1'b1;
      dig   = 16'h1234;
      dp    = 4'b0001;
      run(3);
      rst_n = 1'b1;
      run(45);
      dig = 16'hFFFF;
      run(72);
      en = 1'b0;
      run(5);
      en  = 1'b1;
      dig = 16'hA5C3;
      run(50);
      async_reset_check();
      run(3);
      rst_n = 1'b1;
      dig   = 16'h0070;
      dp    = 4'b1000;
      run(70);
      dig = 16'h0000;
      dp  = 4'b0000;
      run(70);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) begin
            case ($urandom_range(3))
               0:       mask = 16'h000F;
               1:       mask = 16'h00FF;
               2:       mask = 16'h0FFF;
               default: mask = 16'hFFFF;
            endcase
            dig = 16'($urandom) & mask;
            dp  = 4'($urandom);
         end
         en = ($urandom_range(99) >= 2);
         if ($urandom_range(499) == 0) begin
            async_reset_check();
            run(2);
            rst_n = 1'b1;
         end
         cycle();
      end

      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d entries expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
